mc_ctrl: RTL and testbench

//  Multi-cycle MIPS control FSM; drives the ALU's ALUctr (addu=00, subu=01, or=10) and consumes its zero flag.

---
 rtl/mc_ctrl_if.sv | 32 +++
 rtl/mc_ctrl.sv | 153 +++++++++++++++
 tb/tb_mc_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle MIPS controller and the shared datapath.
// master = controller side (reads IR fields and zero, drives enables/selects).
interface mc_ctrl_if #(
  parameter int ST_W = 4
);
  logic [5:0]      op;
  logic [5:0]      funct;
  logic            zero;
  logic            pc_wr;
  logic [1:0]      npc_sel;
  logic            ir_wr;
  logic            reg_wr;
  logic [1:0]      reg_dst;
  logic [1:0]      wd_sel;
  logic            mem_wr;
  logic            alu_src;
  logic            ext_op;
  logic [1:0]      ALUctr;
  logic [ST_W-1:0] state_o;

  modport master (
    input  op, funct, zero,
    output pc_wr, npc_sel, ir_wr, reg_wr, reg_dst, wd_sel,
           mem_wr, alu_src, ext_op, ALUctr, state_o
  );

  modport slave (
    output op, funct, zero,
    input  pc_wr, npc_sel, ir_wr, reg_wr, reg_dst, wd_sel,
           mem_wr, alu_src, ext_op, ALUctr, state_o
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM (fetch/decode/execute/memory/writeback), Moore/decode outputs.
// Optional MC_CTRL_BNE_EN: decodes bne (op 000101) onto the branch state with an inverted zero test.
module mc_ctrl #(
  parameter int ST_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  mc_ctrl_if.master  bus
);
  localparam logic [ST_W-1:0] S_FETCH = ST_W'(0);
  localparam logic [ST_W-1:0] S_DCD   = ST_W'(1);
  localparam logic [ST_W-1:0] S_EXE   = ST_W'(2);
  localparam logic [ST_W-1:0] S_MA    = ST_W'(3);
  localparam logic [ST_W-1:0] S_MRD   = ST_W'(4);
  localparam logic [ST_W-1:0] S_MWR   = ST_W'(5);
  localparam logic [ST_W-1:0] S_WB    = ST_W'(6);
  localparam logic [ST_W-1:0] S_MWB   = ST_W'(7);
  localparam logic [ST_W-1:0] S_BR    = ST_W'(8);
  localparam logic [ST_W-1:0] S_JMP   = ST_W'(9);

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  logic [ST_W-1:0] state_q, state_d;

  logic is_addu, is_subu, is_jr, is_ori, is_lw, is_sw;
  logic is_beq, is_bne, is_lui, is_j, is_jal;

  assign is_addu = (bus.op == OP_R) && (bus.funct == FN_ADDU);
  assign is_subu = (bus.op == OP_R) && (bus.funct == FN_SUBU);
  assign is_jr   = (bus.op == OP_R) && (bus.funct == FN_JR);
  assign is_ori  = (bus.op == OP_ORI);
  assign is_lw   = (bus.op == OP_LW);
  assign is_sw   = (bus.op == OP_SW);
  assign is_beq  = (bus.op == OP_BEQ);
  assign is_lui  = (bus.op == OP_LUI);
  assign is_j    = (bus.op == OP_J);
  assign is_jal  = (bus.op == OP_JAL);
`ifdef MC_CTRL_BNE_EN
  assign is_bne  = (bus.op == 6'b000101);
`else
  assign is_bne  = 1'b0;
`endif

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DCD;
      S_DCD: begin
        if (is_addu || is_subu || is_ori || is_lui) state_d = S_EXE;
        else if (is_lw || is_sw)                    state_d = S_MA;
        else if (is_beq || is_bne)                  state_d = S_BR;
        else if (is_j || is_jal || is_jr)           state_d = S_JMP;
        else                                        state_d = S_FETCH;
      end
      S_EXE:   state_d = S_WB;
      S_MA:    state_d = is_lw ? S_MRD : S_MWR;
      S_MRD:   state_d = S_MWB;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  logic       pc_wr, ir_wr, reg_wr, mem_wr, alu_src, ext_op;
  logic [1:0] npc_sel, reg_dst, wd_sel, alu_ctr;

  always_comb begin
    pc_wr   = 1'b0;
    npc_sel = 2'b00;
    ir_wr   = 1'b0;
    reg_wr  = 1'b0;
    reg_dst = 2'b00;
    wd_sel  = 2'b00;
    mem_wr  = 1'b0;
    alu_src = 1'b0;
    ext_op  = 1'b0;
    alu_ctr = 2'b00;
    case (state_q)
      S_FETCH: begin
        pc_wr = 1'b1;
        ir_wr = 1'b1;
      end
      S_EXE: begin
        if (is_subu) alu_ctr = 2'b01;
        else if (is_ori) begin
          alu_ctr = 2'b10;
          alu_src = 1'b1;
        end
      end
      S_WB: begin
        reg_wr = 1'b1;
        if (bus.op == OP_R) reg_dst = 2'b01;
        if (is_lui)         wd_sel  = 2'b11;
      end
      S_MA: begin
        alu_src = 1'b1;
        ext_op  = 1'b1;
      end
      S_MWR: mem_wr = 1'b1;
      S_MWB: begin
        reg_wr = 1'b1;
        wd_sel = 2'b01;
      end
      S_BR: begin
        npc_sel = 2'b01;
        alu_ctr = 2'b01;
        pc_wr   = is_bne ? ~bus.zero : bus.zero;
      end
      S_JMP: begin
        pc_wr   = 1'b1;
        npc_sel = is_jr ? 2'b11 : 2'b10;
        if (is_jal) begin
          reg_wr  = 1'b1;
          reg_dst = 2'b10;
          wd_sel  = 2'b10;
        end
      end
      default: ;
    endcase
    // Reset suppresses every write so an interrupted instruction leaves no trace.
    if (reset) begin
      pc_wr  = 1'b0;
      ir_wr  = 1'b0;
      reg_wr = 1'b0;
      mem_wr = 1'b0;
    end
  end

  assign bus.pc_wr   = pc_wr;
  assign bus.npc_sel = npc_sel;
  assign bus.ir_wr   = ir_wr;
  assign bus.reg_wr  = reg_wr;
  assign bus.reg_dst = reg_dst;
  assign bus.wd_sel  = wd_sel;
  assign bus.mem_wr  = mem_wr;
  assign bus.alu_src = alu_src;
  assign bus.ext_op  = ext_op;
  assign bus.ALUctr  = alu_ctr;
  assign bus.state_o = state_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class state by state against hand-written values.
module tb_mc_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  mc_ctrl_if #(.ST_W(4)) bus ();

  mc_ctrl #(.ST_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Packing order: pc_wr npc_sel ir_wr reg_wr reg_dst wd_sel mem_wr alu_src ext_op ALUctr
  logic [13:0] ctrl;
  assign ctrl = {bus.pc_wr, bus.npc_sel, bus.ir_wr, bus.reg_wr, bus.reg_dst, bus.wd_sel,
                 bus.mem_wr, bus.alu_src, bus.ext_op, bus.ALUctr};

  function automatic logic [13:0] c(input logic pw, input logic [1:0] ns, input logic iw,
                                    input logic rw, input logic [1:0] rd, input logic [1:0] wd,
                                    input logic mw, input logic as_, input logic eo,
                                    input logic [1:0] alu);
    return {pw, ns, iw, rw, rd, wd, mw, as_, eo, alu};
  endfunction

  localparam logic [5:0] R = 6'b000000;

  task automatic step(input string tag, input logic [5:0] o, input logic [5:0] f, input logic z,
                      input logic [3:0] es, input logic [13:0] ec);
    bus.op = o;
    bus.funct = f;
    bus.zero = z;
    #1;
    total++;
    assert (bus.state_o === es) else begin
      bad++;
      $error("FAIL %s state: got %0d want %0d", tag, bus.state_o, es);
    end
    total++;
    assert (ctrl === ec) else begin
      bad++;
      $error("FAIL %s ctrl: got %b want %b", tag, ctrl, ec);
    end
    @(posedge clk);
    #1;
  endtask

  logic [13:0] c0, cf, cwb_r;
  initial begin
    c0    = '0;
    cf    = c(1, 2'b00, 1, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00);
    cwb_r = c(0, 2'b00, 0, 1, 2'b01, 2'b00, 0, 0, 0, 2'b00);
    bus.op = '0;
    bus.funct = '0;
    bus.zero = 1'b0;

    @(posedge clk);
    #1;
    step("rst_hold", R, 6'd0, 0, 4'd0, c0);
    reset = 1'b0;

    step("addu_f", R, 6'b100001, 0, 4'd0, cf);
    step("addu_d", R, 6'b100001, 0, 4'd1, c0);
    step("addu_e", R, 6'b100001, 0, 4'd2, c0);
    step("addu_w", R, 6'b100001, 0, 4'd6, cwb_r);

    step("subu_f", R, 6'b100011, 0, 4'd0, cf);
    step("subu_d", R, 6'b100011, 0, 4'd1, c0);
    step("subu_e", R, 6'b100011, 0, 4'd2, c(0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b01));
    step("subu_w", R, 6'b100011, 0, 4'd6, cwb_r);

    step("ori_f", 6'b001101, 6'd5, 0, 4'd0, cf);
    step("ori_d", 6'b001101, 6'd5, 0, 4'd1, c0);
    step("ori_e", 6'b001101, 6'd5, 0, 4'd2, c(0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 1, 0, 2'b10));
    step("ori_w", 6'b001101, 6'd5, 0, 4'd6, c(0, 2'b00, 0, 1, 2'b00, 2'b00, 0, 0, 0, 2'b00));

    step("lui_f", 6'b001111, 6'd0, 0, 4'd0, cf);
    step("lui_d", 6'b001111, 6'd0, 0, 4'd1, c0);
    step("lui_e", 6'b001111, 6'd0, 0, 4'd2, c0);
    step("lui_w", 6'b001111, 6'd0, 0, 4'd6, c(0, 2'b00, 0, 1, 2'b00, 2'b11, 0, 0, 0, 2'b00));

    step("lw_f",   6'b100011, 6'd0, 0, 4'd0, cf);
    step("lw_d",   6'b100011, 6'd0, 0, 4'd1, c0);
    step("lw_ma",  6'b100011, 6'd0, 0, 4'd3, c(0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 1, 1, 2'b00));
    step("lw_mrd", 6'b100011, 6'd0, 0, 4'd4, c0);
    step("lw_mwb", 6'b100011, 6'd0, 0, 4'd7, c(0, 2'b00, 0, 1, 2'b00, 2'b01, 0, 0, 0, 2'b00));

    step("sw_f",   6'b101011, 6'd0, 0, 4'd0, cf);
    step("sw_d",   6'b101011, 6'd0, 0, 4'd1, c0);
    step("sw_ma",  6'b101011, 6'd0, 0, 4'd3, c(0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 1, 1, 2'b00));
    step("sw_mwr", 6'b101011, 6'd0, 0, 4'd5, c(0, 2'b00, 0, 0, 2'b00, 2'b00, 1, 0, 0, 2'b00));

    step("beq1_f",  6'b000100, 6'd0, 1, 4'd0, cf);
    step("beq1_d",  6'b000100, 6'd0, 1, 4'd1, c0);
    step("beq1_br", 6'b000100, 6'd0, 1, 4'd8, c(1, 2'b01, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b01));
    step("beq0_f",  6'b000100, 6'd0, 0, 4'd0, cf);
    step("beq0_d",  6'b000100, 6'd0, 0, 4'd1, c0);
    step("beq0_br", 6'b000100, 6'd0, 0, 4'd8, c(0, 2'b01, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b01));

    step("j_f",     6'b000010, 6'd0, 0, 4'd0, cf);
    step("j_d",     6'b000010, 6'd0, 0, 4'd1, c0);
    step("j_jmp",   6'b000010, 6'd0, 0, 4'd9, c(1, 2'b10, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00));
    step("jal_f",   6'b000011, 6'd0, 0, 4'd0, cf);
    step("jal_d",   6'b000011, 6'd0, 0, 4'd1, c0);
    step("jal_jmp", 6'b000011, 6'd0, 0, 4'd9, c(1, 2'b10, 0, 1, 2'b10, 2'b10, 0, 0, 0, 2'b00));
    step("jr_f",    R, 6'b001000, 0, 4'd0, cf);
    step("jr_d",    R, 6'b001000, 0, 4'd1, c0);
    step("jr_jmp",  R, 6'b001000, 0, 4'd9, c(1, 2'b11, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00));

    step("undef_f", 6'b111111, 6'd0, 0, 4'd0, cf);
    step("undef_d", 6'b111111, 6'd0, 0, 4'd1, c0);
    step("sll_f",   R, 6'd0, 0, 4'd0, cf);
    step("sll_d",   R, 6'd0, 0, 4'd1, c0);

    step("bne_f", 6'b000101, 6'd0, 0, 4'd0, cf);
    step("bne_d", 6'b000101, 6'd0, 0, 4'd1, c0);
`ifdef MC_CTRL_BNE_EN
    step("bne_br", 6'b000101, 6'd0, 0, 4'd8, c(1, 2'b01, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b01));
`endif

    step("rlw_f",  6'b100011, 6'd0, 0, 4'd0, cf);
    step("rlw_d",  6'b100011, 6'd0, 0, 4'd1, c0);
    step("rlw_ma", 6'b100011, 6'd0, 0, 4'd3, c(0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 1, 1, 2'b00));
    reset = 1'b1;
    step("rst_mrd", 6'b100011, 6'd0, 0, 4'd4, c0);
    step("rst_2nd", 6'b100011, 6'd0, 0, 4'd0, c0);
    reset = 1'b0;

    step("rsw_f",  6'b101011, 6'd0, 0, 4'd0, cf);
    step("rsw_d",  6'b101011, 6'd0, 0, 4'd1, c0);
    step("rsw_ma", 6'b101011, 6'd0, 0, 4'd3, c(0, 2'b00, 0, 0, 2'b00, 2'b00, 0, 1, 1, 2'b00));
    reset = 1'b1;
    step("rst_mwr", 6'b101011, 6'd0, 0, 4'd5, c0);
    reset = 1'b0;
    step("post_rst", 6'b101011, 6'd0, 0, 4'd0, cf);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
